// File: rtl/anchor_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : anchor_cmd_queue                                                |
// | Function : Command FIFO and issue sequencer in front of the anchor Updater.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module anchor_cmd_queue #(
    parameter int FEATURE_WIDTH  = 400,
    parameter int ENCODE_WIDTH   = 12,
    parameter int LEVEL_WIDTH    = 2,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_op,
    input  logic [LEVEL_WIDTH+ENCODE_WIDTH-1:0]  cmd_pos,
    input  logic [FEATURE_WIDTH-1:0]             cmd_feature,
    output logic                                 add_anchor,
    output logic                                 del_anchor,
    output logic [LEVEL_WIDTH+ENCODE_WIDTH-1:0]  pos_encode,
    output logic [FEATURE_WIDTH-1:0]             feature_in,
    input  logic                                 add_done,
    input  logic                                 del_done,
    output logic                                 busy,
    output logic [$clog2(DEPTH):0]               fifo_count,
    input  logic                                 err_clr,
    output logic                                 err_level,
    output logic                                 err_proto,
    output logic                                 err_timeout
);

    localparam int c_POS_W = LEVEL_WIDTH + ENCODE_WIDTH;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                   r_state_q, w_state_d;
    logic [c_PTR_W-1:0]       r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]       r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]       r_count_q, w_count_d;
    logic [c_TMR_W-1:0]       r_timer_q, w_timer_d;
    logic                     r_op_q, w_op_d;
    logic [c_POS_W-1:0]       r_pos_q, w_pos_d;
    logic [FEATURE_WIDTH-1:0] r_feat_q, w_feat_d;
    logic                     r_err_level_q, w_err_level_d;
    logic                     r_err_proto_q, w_err_proto_d;
    logic                     r_err_timeout_q, w_err_timeout_d;

    logic                     r_op_mem_q   [DEPTH];
    logic [c_POS_W-1:0]       r_pos_mem_q  [DEPTH];
    logic [FEATURE_WIDTH-1:0] r_feat_mem_q [DEPTH];

    logic                     w_push;
    logic                     w_pop;
    logic                     w_head_op;
    logic [c_POS_W-1:0]       w_head_pos;
    logic                     w_head_invalid;
    logic                     w_match;
    logic                     w_set_level;
    logic                     w_set_proto;
    logic                     w_set_timeout;

    assign cmd_ready      = (r_count_q < c_DEPTH_CNT);
    assign w_push         = cmd_valid & cmd_ready;
    // Every IDLE cycle with a non-empty queue consumes the head entry.
    assign w_pop          = (r_state_q == S_IDLE) && (r_count_q != '0);
    assign w_head_op      = r_op_mem_q[r_rd_ptr_q];
    assign w_head_pos     = r_pos_mem_q[r_rd_ptr_q];
    assign w_head_invalid = &w_head_pos[c_POS_W-1 -: LEVEL_WIDTH];
    // With both dones high the matching one wins, so only the op's own done is checked.
    assign w_match        = r_op_q ? del_done : add_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem_q[r_wr_ptr_q]   <= cmd_op;
            r_pos_mem_q[r_wr_ptr_q]  <= cmd_pos;
            r_feat_mem_q[r_wr_ptr_q] <= cmd_feature;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_count_d     = r_count_q;
        w_timer_d     = r_timer_q;
        w_op_d        = r_op_q;
        w_pos_d       = r_pos_q;
        w_feat_d      = r_feat_q;
        w_set_level   = 1'b0;
        w_set_timeout = 1'b0;

        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase

        case (r_state_q)
            S_IDLE: begin
                if (w_pop) begin
                    if (w_head_invalid) begin
                        w_set_level = 1'b1;
                    end else begin
                        w_state_d = S_ISSUE;
                        w_op_d    = w_head_op;
                        w_pos_d   = w_head_pos;
                        w_feat_d  = r_feat_mem_q[r_rd_ptr_q];
                    end
                end
            end
            S_ISSUE: begin
                w_state_d = S_WAIT;
                w_timer_d = '0;
            end
            S_WAIT: begin
                if (w_match) begin
                    w_state_d = S_IDLE;
                end else if (r_timer_q == c_TMR_LAST) begin
                    w_set_timeout = 1'b1;
                    w_state_d     = S_IDLE;
                end else begin
                    w_timer_d = r_timer_q + c_TMR_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // In WAIT only the other op's done is unexpected; elsewhere any done is.
        if (r_state_q == S_WAIT) begin
            w_set_proto = r_op_q ? add_done : del_done;
        end else begin
            w_set_proto = add_done | del_done;
        end

        w_err_level_d   = w_set_level   | (r_err_level_q   & ~err_clr);
        w_err_proto_d   = w_set_proto   | (r_err_proto_q   & ~err_clr);
        w_err_timeout_d = w_set_timeout | (r_err_timeout_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= S_IDLE;
            r_wr_ptr_q      <= '0;
            r_rd_ptr_q      <= '0;
            r_count_q       <= '0;
            r_timer_q       <= '0;
            r_op_q          <= 1'b0;
            r_pos_q         <= '0;
            r_feat_q        <= '0;
            r_err_level_q   <= 1'b0;
            r_err_proto_q   <= 1'b0;
            r_err_timeout_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_wr_ptr_q      <= w_wr_ptr_d;
            r_rd_ptr_q      <= w_rd_ptr_d;
            r_count_q       <= w_count_d;
            r_timer_q       <= w_timer_d;
            r_op_q          <= w_op_d;
            r_pos_q         <= w_pos_d;
            r_feat_q        <= w_feat_d;
            r_err_level_q   <= w_err_level_d;
            r_err_proto_q   <= w_err_proto_d;
            r_err_timeout_q <= w_err_timeout_d;
        end
    end

    assign add_anchor  = (r_state_q == S_ISSUE) & ~r_op_q;
    assign del_anchor  = (r_state_q == S_ISSUE) &  r_op_q;
    assign pos_encode  = r_pos_q;
    assign feature_in  = r_feat_q;
    assign busy        = (r_state_q != S_IDLE) || (r_count_q != '0);
    assign fifo_count  = r_count_q;
    assign err_level   = r_err_level_q;
    assign err_proto   = r_err_proto_q;
    assign err_timeout = r_err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_anchor_cmd_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_anchor_cmd_queue                                             |
// | Function : Directed vector bench for the anchor command queue.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_anchor_cmd_queue;

    localparam int FW = 400;
    localparam int PW = 14;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [PW-1:0] cmd_pos;
    logic [FW-1:0] cmd_feature;
    logic          add_anchor;
    logic          del_anchor;
    logic [PW-1:0] pos_encode;
    logic [FW-1:0] feature_in;
    logic          add_done;
    logic          del_done;
    logic          busy;
    logic [2:0]    fifo_count;
    logic          err_clr;
    logic          err_level;
    logic          err_proto;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    anchor_cmd_queue #(
        .FEATURE_WIDTH  (FW),
        .ENCODE_WIDTH   (12),
        .LEVEL_WIDTH    (2),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_pos     (cmd_pos),
        .cmd_feature (cmd_feature),
        .add_anchor  (add_anchor),
        .del_anchor  (del_anchor),
        .pos_encode  (pos_encode),
        .feature_in  (feature_in),
        .add_done    (add_done),
        .del_done    (del_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .err_clr     (err_clr),
        .err_level   (err_level),
        .err_proto   (err_proto),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid, op;
        logic [PW-1:0] pos;
        logic          fone, ad, dd, clr;
        logic          rdy, add, del;
        logic [PW-1:0] epos;
        logic          efone, busy;
        logic [2:0]    cnt;
        logic          el, ep, et;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic v, input logic op, input logic [PW-1:0] pos, input logic f,
        input logic ad, input logic dd, input logic clr,
        input logic rdy, input logic add, input logic del, input logic [PW-1:0] epos,
        input logic ef, input logic bsy, input logic [2:0] cnt,
        input logic el, input logic ep, input logic et);
        vec_t r;
        r.valid = v;   r.op = op;     r.pos = pos;   r.fone = f;
        r.ad = ad;     r.dd = dd;     r.clr = clr;
        r.rdy = rdy;   r.add = add;   r.del = del;   r.epos = epos;
        r.efone = ef;  r.busy = bsy;  r.cnt = cnt;
        r.el = el;     r.ep = ep;     r.et = et;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic op, input logic [PW-1:0] pos, input logic fone);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_pos     = pos;
        cmd_feature = {FW{fone}};
    endtask

    // Waits (bounded) for the next pulse, then checks what was issued and how soon.
    task automatic issue_check(input string name, input logic op, input logic [PW-1:0] pos,
                               input logic fone, input int lat);
        int n = 0;
        while (!(add_anchor || del_anchor) && n < 20) begin
            step();
            n++;
        end
        chk({name, "_pulse"}, {add_anchor, del_anchor}, {~op, op});
        chk({name, "_pos"}, pos_encode, pos);
        chk({name, "_feat"}, (feature_in === {FW{fone}}), 1'b1);
        if (lat >= 0) chk({name, "_latency"}, n, lat);
    endtask

    // From the pulse cycle: answer with the matching done one cycle into WAIT.
    task automatic complete(input logic op);
        step();
        add_done = ~op;
        del_done = op;
        step();
        add_done = 1'b0;
        del_done = 1'b0;
    endtask

    int exp_cnt[6] = '{0, 1, 1, 2, 3, 4};

    initial begin
        logic [24:0] act;
        logic [24:0] exp;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_pos = '0; cmd_feature = '0;
        add_done = 1'b0; del_done = 1'b0; err_clr = 1'b0;

        //      v op pos      f  ad dd cl  rdy add del epos     ef bsy cnt el ep et
        tv.push_back(mk(1, 0, 14'h005, 1, 0, 0, 0, 1, 0, 0, 14'h000, 0, 0, 3'd0, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h000, 0, 1, 3'd1, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 1, 0, 14'h005, 1, 1, 3'd0, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h005, 1, 1, 3'd0, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h005, 1, 1, 3'd0, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 1, 0, 0, 1, 0, 0, 14'h005, 1, 1, 3'd0, 0, 0, 0));
        tv.push_back(mk(1, 0, 14'h005, 1, 0, 0, 0, 1, 0, 0, 14'h005, 1, 0, 3'd0, 0, 0, 0));
        tv.push_back(mk(1, 1, 14'h005, 1, 0, 0, 0, 1, 0, 0, 14'h005, 1, 1, 3'd1, 0, 0, 0));
        tv.push_back(mk(1, 0, 14'h00A, 0, 0, 0, 0, 1, 1, 0, 14'h005, 1, 1, 3'd1, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h005, 1, 1, 3'd2, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 1, 0, 0, 1, 0, 0, 14'h005, 1, 1, 3'd2, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h005, 1, 1, 3'd2, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 1, 14'h005, 1, 1, 3'd1, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 1, 0, 1, 0, 0, 14'h005, 1, 1, 3'd1, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h005, 1, 1, 3'd1, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 1, 0, 14'h00A, 0, 1, 3'd0, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 1, 0, 0, 1, 0, 0, 14'h00A, 0, 1, 3'd0, 0, 0, 0));
        tv.push_back(mk(1, 0, 14'h3005, 1, 0, 0, 0, 1, 0, 0, 14'h00A, 0, 0, 3'd0, 0, 0, 0));
        tv.push_back(mk(1, 0, 14'h006, 1, 0, 0, 0, 1, 0, 0, 14'h00A, 0, 1, 3'd1, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h00A, 0, 1, 3'd1, 1, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 1, 0, 14'h006, 1, 1, 3'd0, 1, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 1, 0, 1, 0, 0, 14'h006, 1, 1, 3'd0, 1, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h006, 1, 1, 3'd0, 1, 1, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 1, 0, 0, 1, 0, 0, 14'h006, 1, 1, 3'd0, 1, 1, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 1, 1, 0, 0, 14'h006, 1, 0, 3'd0, 1, 1, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 1, 0, 0, 1, 0, 0, 14'h006, 1, 0, 3'd0, 0, 0, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 1, 1, 1, 0, 0, 14'h006, 1, 0, 3'd0, 0, 1, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 1, 1, 0, 0, 14'h006, 1, 0, 3'd0, 0, 1, 0));
        tv.push_back(mk(0, 0, 14'h000, 0, 0, 0, 0, 1, 0, 0, 14'h006, 1, 0, 3'd0, 0, 0, 0));

        repeat (3) step();
        rst = 1'b0;

        // Single add, back-to-back, invalid level, protocol error and err_clr.
        foreach (tv[i]) begin
            cmd_valid   = tv[i].valid;
            cmd_op      = tv[i].op;
            cmd_pos     = tv[i].pos;
            cmd_feature = {FW{tv[i].fone}};
            add_done    = tv[i].ad;
            del_done    = tv[i].dd;
            err_clr     = tv[i].clr;
            act = {cmd_ready, add_anchor, del_anchor, pos_encode,
                   (feature_in === {FW{tv[i].efone}}), busy, fifo_count,
                   err_level, err_proto, err_timeout};
            exp = {tv[i].rdy, tv[i].add, tv[i].del, tv[i].epos, 1'b1, tv[i].busy,
                   tv[i].cnt, tv[i].el, tv[i].ep, tv[i].et};
            chk($sformatf("vec%0d", i), act, exp);
            step();
        end

        // Full FIFO with the Updater stalled: six offered, five accepted.
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_ready%0d", i), cmd_ready, (i < 5));
            chk($sformatf("t3_count%0d", i), fifo_count, exp_cnt[i]);
            chk($sformatf("t3_pulse%0d", i), {add_anchor, del_anchor}, (i == 2) ? 2'b10 : 2'b00);
            push(i[0], 14'(16 + i), i[0]);
            step();
        end
        cmd_valid = 1'b0;
        chk("t3_full_count", fifo_count, 3'd4);
        chk("t3_full_ready", cmd_ready, 1'b0);
        chk("t3_c0_pos", pos_encode, 14'h010);
        complete(1'b0);
        for (int k = 1; k < 5; k++) begin
            issue_check($sformatf("t3_c%0d", k), k[0], 14'(16 + k), k[0], 1);
            complete(k[0]);
        end
        chk("t3_drained_busy", busy, 1'b0);
        chk("t3_drained_count", fifo_count, 3'd0);

        // Timeout after 16 WAIT cycles, then the next command issues.
        push(1'b0, 14'h020, 1'b0);
        step();
        push(1'b0, 14'h021, 1'b1);
        step();
        cmd_valid = 1'b0;
        issue_check("t6_first", 1'b0, 14'h020, 1'b0, 0);
        repeat (16) step();
        chk("t6_no_timeout_yet", err_timeout, 1'b0);
        chk("t6_still_waiting", {add_anchor, del_anchor}, 2'b00);
        step();
        chk("t6_timeout", err_timeout, 1'b1);
        chk("t6_busy", busy, 1'b1);
        chk("t6_count", fifo_count, 3'd1);
        issue_check("t6_second", 1'b0, 14'h021, 1'b1, 1);

        // Reset mid-WAIT with one entry still queued.
        push(1'b1, 14'h022, 1'b1);
        step();
        cmd_valid = 1'b0;
        step();
        chk("t6_wait_count", fifo_count, 3'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_outputs", {cmd_ready, add_anchor, del_anchor, pos_encode, busy, fifo_count,
                            err_level, err_proto, err_timeout},
                           {1'b1, 1'b0, 1'b0, 14'h000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
        chk("rst_feature", (feature_in === {FW{1'b0}}), 1'b1);
        repeat (3) step();
        chk("rst_fifo_empty", {add_anchor, del_anchor, busy, fifo_count}, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
